// File: rtl/class_vote_collector.sv
// Byte-stream feature assembler and per-class vote reducer wrapped around a
// combinational decision-tree bank; returns the winning class on valid/ready.
module class_vote_collector #(
  parameter int NUM_FEAT    = 51,
  parameter int NUM_CLASSES = 6,
  parameter int NUM_TREES   = 4,
  parameter int EVAL_CYCLES = 1,
  parameter int CLASS_W     = 3,
  parameter int CNT_W       = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [7:0]                       in_data,
  output logic [NUM_FEAT-1:0]              feat,
  output logic                             feat_valid,
  input  logic [NUM_CLASSES*NUM_TREES-1:0] tree_votes,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CLASS_W-1:0]               out_class,
  output logic [CNT_W-1:0]                 out_votes
);

  localparam int NBYTES = (NUM_FEAT + 7) / 8;
  localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int EC_W   = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES + 1) : 1;
  localparam int NV     = NUM_CLASSES * NUM_TREES;

  typedef enum logic [1:0] {LOAD, EVAL, SCAN, OUT} state_e;

  state_e              state_q;
  logic [BI_W-1:0]     byte_idx_q;
  logic [NUM_FEAT-1:0] feat_q, feat_d;
  logic [EC_W-1:0]     eval_cnt_q;
  logic [NV-1:0]       votes_q;
  logic [CLASS_W-1:0]  cls_idx_q, best_cls_q, best_cls_d;
  logic [CNT_W-1:0]    best_cnt_q, best_cnt_d, cnt_cur;
  logic [NUM_TREES-1:0] slice;
  logic [NBYTES*8-1:0] feat_wide;
  logic                in_ready_q, feat_valid_q, out_valid_q;
  logic [CLASS_W-1:0]  out_class_q;
  logic [CNT_W-1:0]    out_votes_q;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_TREES-1:0] s);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int t = 0; t < NUM_TREES; t++) n = n + CNT_W'(s[t]);
    return n;
  endfunction

  // Bits above NUM_FEAT in the final byte fall off when narrowing back.
  always_comb begin
    feat_wide = '0;
    feat_wide[NUM_FEAT-1:0] = feat_q;
    feat_wide[int'(byte_idx_q)*8 +: 8] = in_data;
    feat_d = feat_wide[NUM_FEAT-1:0];
  end

  // Strict compare keeps the lower class index on ties and never lets a
  // zero-vote class displace the initial class 0 / count 0.
  always_comb begin
    slice      = NUM_TREES'(votes_q >> (int'(cls_idx_q) * NUM_TREES));
    cnt_cur    = popcount(slice);
    best_cnt_d = best_cnt_q;
    best_cls_d = best_cls_q;
    if (cnt_cur > best_cnt_q) begin
      best_cnt_d = cnt_cur;
      best_cls_d = cls_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      byte_idx_q   <= '0;
      feat_q       <= '0;
      eval_cnt_q   <= '0;
      votes_q      <= '0;
      cls_idx_q    <= '0;
      best_cnt_q   <= '0;
      best_cls_q   <= '0;
      in_ready_q   <= 1'b1;
      feat_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_votes_q  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid && in_ready_q) begin
            feat_q <= feat_d;
            if (byte_idx_q == BI_W'(NBYTES - 1)) begin
              byte_idx_q   <= '0;
              eval_cnt_q   <= EC_W'(EVAL_CYCLES);
              in_ready_q   <= 1'b0;
              feat_valid_q <= 1'b1;
              state_q      <= EVAL;
            end else begin
              byte_idx_q <= byte_idx_q + BI_W'(1);
            end
          end
        end
        EVAL: begin
          eval_cnt_q <= eval_cnt_q - EC_W'(1);
          if (eval_cnt_q == EC_W'(1)) begin
            votes_q    <= tree_votes;
            cls_idx_q  <= '0;
            best_cnt_q <= '0;
            best_cls_q <= '0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          best_cnt_q <= best_cnt_d;
          best_cls_q <= best_cls_d;
          if (cls_idx_q == CLASS_W'(NUM_CLASSES - 1)) begin
            out_class_q <= best_cls_d;
            out_votes_q <= best_cnt_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            cls_idx_q <= cls_idx_q + CLASS_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            feat_valid_q <= 1'b0;
            byte_idx_q   <= '0;
            state_q      <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign feat       = feat_q;
  assign feat_valid = feat_valid_q;
  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_votes  = out_votes_q;

endmodule

// File: tb/tb_class_vote_collector.sv
// Scoreboard bench for class_vote_collector: one instance with EVAL_CYCLES=1
// and one with EVAL_CYCLES=3 share stimulus; the idle one is held in reset.
module tb_class_vote_collector;
  localparam int NF = 51;
  localparam int NC = 6;
  localparam int NT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1_n, rst3_n, in_valid, out_ready, sel;
  logic [7:0]  in_data;
  logic [23:0] tree_votes;
  logic        ir1, fv1, ov1, ir3, fv3, ov3;
  logic [50:0] f1, f3;
  logic [2:0]  oc1, oc3, on1, on3;

  class_vote_collector #(.EVAL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .feat(f1), .feat_valid(fv1), .tree_votes(tree_votes), .out_valid(ov1),
    .out_ready(out_ready), .out_class(oc1), .out_votes(on1));

  class_vote_collector #(.EVAL_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
    .feat(f3), .feat_valid(fv3), .tree_votes(tree_votes), .out_valid(ov3),
    .out_ready(out_ready), .out_class(oc3), .out_votes(on3));

  logic        o_ir, o_fv, o_ov;
  logic [50:0] o_feat;
  logic [2:0]  o_cls, o_cnt;
  assign o_ir   = sel ? ir3 : ir1;
  assign o_fv   = sel ? fv3 : fv1;
  assign o_ov   = sel ? ov3 : ov1;
  assign o_feat = sel ? f3  : f1;
  assign o_cls  = sel ? oc3 : oc1;
  assign o_cnt  = sel ? on3 : on1;

  int total = 0;
  int bad   = 0;
  logic [5:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst3_n = v;
    else     rst1_n = v;
  endtask

  // Winner = highest count; among equal counts the first (lowest) index.
  function automatic logic [5:0] model(input logic [23:0] v);
    int mx;
    logic [5:0] r;
    logic found;
    mx = 0;
    r = '0;
    found = 1'b0;
    for (int i = 0; i < NC; i++)
      if ($countones(v[i*NT +: NT]) > mx) mx = $countones(v[i*NT +: NT]);
    for (int i = 0; i < NC; i++)
      if (!found && $countones(v[i*NT +: NT]) == mx) begin
        r = {3'(i), 3'(mx)};
        found = 1'b1;
      end
    return r;
  endfunction

  task automatic check_reset_state();
    check("rst_in_ready", 64'(o_ir), 64'd1);
    check("rst_feat", 64'(o_feat), 64'd0);
    check("rst_feat_valid", 64'(o_fv), 64'd0);
    check("rst_out_valid", 64'(o_ov), 64'd0);
    check("rst_out_class", 64'(o_cls), 64'd0);
    check("rst_out_votes", 64'(o_cnt), 64'd0);
  endtask

  task automatic run_vec(input logic [55:0] bv, input logic [23:0] v,
                         input int gap, input int stall);
    int n, ev;
    logic [50:0] hf;
    logic [5:0]  got, exp;
    ev = sel ? 3 : 1;
    sb.push_back(model(v));
    out_ready  = (stall == 0);
    tree_votes = ~v;
    for (int k = 0; k < 7; k++) begin
      if (k > 0)
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          step();
        end
      in_valid = 1'b1;
      in_data  = bv[8*k +: 8];
      check("in_ready_load", 64'(o_ir), 64'd1);
      step();
    end
    in_valid = 1'b0;
    check("feat", 64'(o_feat), 64'(bv[50:0]));
    check("feat_valid_c1", 64'(o_fv), 64'd1);
    check("in_ready_c1", 64'(o_ir), 64'd0);
    n = 1;
    while (!o_ov && n < 64) begin
      tree_votes = (n == ev) ? v : ~v;
      step();
      n++;
    end
    check("out_valid_cycle", 64'(n), 64'(ev + 7));
    hf = o_feat;
    got = {o_cls, o_cnt};
    for (int s = 0; s < stall; s++) begin
      in_valid   = 1'($urandom);
      in_data    = 8'($urandom);
      tree_votes = 24'($urandom);
      step();
      check("stall_hold", {o_ov, o_ir, o_fv, o_cls, o_cnt, o_feat},
            {1'b1, 1'b0, 1'b1, got, hf});
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("sb_size", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check("result", 64'(got), 64'(exp));
    end
    check("out_valid_drop", 64'(o_ov), 64'd0);
    check("in_ready_after", 64'(o_ir), 64'd1);
  endtask

  task automatic abort_vec(input logic [55:0] bv, input int nbytes, input int extra);
    for (int k = 0; k < nbytes; k++) begin
      in_valid = 1'b1;
      in_data  = bv[8*k +: 8];
      step();
    end
    in_valid = 1'b0;
    for (int e = 0; e < extra; e++) step();
    set_rst(1'b0);
    step();
    check_reset_state();
    set_rst(1'b1);
    step();
    check("post_rst_out_valid", 64'(o_ov), 64'd0);
  endtask

  localparam logic [55:0] SEQ = 56'h07_06_05_04_03_02_01;

  initial begin
    sel = 1'b0;
    rst1_n = 1'b0; rst3_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; tree_votes = '0;
    step(); step();
    rst1_n = 1'b1;
    check_reset_state();

    run_vec(SEQ, 24'h58B043, 0, 0);
    run_vec(56'hFF_A5_5A_C3_3C_96_69, 24'h1F11F1, 0, 0);
    run_vec(SEQ, 24'h000000, 0, 0);
    run_vec(56'h87_11_22_33_44_55_66, 24'h9C3A51, 0, 10);
    abort_vec(56'hDE_AD_BE_EF_12_34_56, 4, 0);
    run_vec(SEQ, 24'h0F0000, 0, 0);
    abort_vec(56'h11_22_33_44_55_66_77, 7, 2);
    run_vec(56'h7F_00_FF_00_FF_00_FF, 24'hF00001, 0, 0);
    for (int r = 0; r < 4; r++)
      run_vec({$urandom, $urandom}, 24'($urandom), int'($urandom_range(0, 2)), 0);

    rst1_n = 1'b0;
    sel = 1'b1;
    rst3_n = 1'b1;
    step();
    check_reset_state();
    run_vec(SEQ, 24'h58B043, 3, 0);
    run_vec(SEQ, 24'h1F11F1, 3, 0);
    for (int r = 0; r < 3; r++)
      run_vec({$urandom, $urandom}, 24'($urandom), int'($urandom_range(0, 1)), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
